discrete_mult_arbiter: RTL and testbench

DISCRETE_MULT_ARBITER -- requirements
Module: discrete_mult_arbiter

---
 rtl/discrete_mult_arbiter.sv | 123 ++++++++++++
 tb/tb_discrete_mult_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/discrete_mult_arbiter.sv
// Round-robin arbiter sharing one signed fixed-point multiplier among NUM_REQ requesters.
// The grant is combinational, and the product appears on a 2-stage pipeline: multiply, then shift/saturate.
module discrete_mult_arbiter #(
  parameter int NUM_REQ               = 4,
  parameter int SIGNAL_WIDTH          = 16,
  parameter int SIGNAL_FRACTION_WIDTH = 14
) (
  input  logic                              clk,
  input  logic                              I_RSTn,
  input  logic                              audio_clk_en,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*SIGNAL_WIDTH-1:0]   op_a,
  input  logic [NUM_REQ*SIGNAL_WIDTH-1:0]   op_b,
  output logic [NUM_REQ-1:0]                gnt,
  output logic signed [SIGNAL_WIDTH-1:0]    result,
  output logic [NUM_REQ-1:0]                result_valid,
  output logic                              busy,
  output logic                              overrun
);

  localparam int W     = SIGNAL_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic signed [2*W-1:0] SAT_MAX = $signed({{(W+1){1'b0}}, {(W-1){1'b1}}});
  localparam logic signed [2*W-1:0] SAT_MIN = $signed({{(W+1){1'b1}}, {(W-1){1'b0}}});

  // Floor shift (arithmetic) followed by clamp into the W-bit signed range.
  function automatic logic signed [W-1:0] shift_sat(input logic signed [2*W-1:0] p);
    logic signed [2*W-1:0] s;
    s = p >>> SIGNAL_FRACTION_WIDTH;
    if (s > SAT_MAX)      shift_sat = SAT_MAX[W-1:0];
    else if (s < SAT_MIN) shift_sat = SAT_MIN[W-1:0];
    else                  shift_sat = s[W-1:0];
  endfunction

  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]        gnt_d;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      found;
  int                        idx;

  logic signed [W-1:0]       a_sel, b_sel;
  logic signed [2*W-1:0]     prod_p1_q;
  logic                      vld_p1_q;
  logic [IDX_W-1:0]          own_p1_q;

  logic signed [W-1:0]       result_p2_q;
  logic [NUM_REQ-1:0]        vld_p2_q, vld_p2_d;
  logic                      overrun_q, overrun_d;

  // Search starts at the requester after the last grant and wraps around.
  always_comb begin
    gnt_d   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt_d[idx]   = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (gnt_idx == IDX_W'(NUM_REQ-1)) ptr_d = '0;
      else                              ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  assign a_sel = $signed(op_a[int'(gnt_idx)*W +: W]);
  assign b_sel = $signed(op_b[int'(gnt_idx)*W +: W]);

  assign vld_p2_d  = vld_p1_q ? (NUM_REQ'(1) << own_p1_q) : '0;
  assign overrun_d = overrun_q | (audio_clk_en & ((|(req & ~gnt_d)) | vld_p1_q));

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      ptr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Stage 1: full-width product with owner tag.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      vld_p1_q <= 1'b0;
      own_p1_q <= '0;
    end else begin
      vld_p1_q <= found;
      if (found) own_p1_q <= gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (found) prod_p1_q <= a_sel * b_sel;
  end

  // Stage 2: shifted/saturated result; holds its value between valid cycles.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      result_p2_q <= '0;
      vld_p2_q    <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      if (vld_p1_q) result_p2_q <= shift_sat(prod_p1_q);
    end
  end

  assign gnt          = gnt_d;
  assign result       = result_p2_q;
  assign result_valid = vld_p2_q;
  assign busy         = (|req) | vld_p1_q | (|vld_p2_q);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_discrete_mult_arbiter.sv
// Directed bench for discrete_mult_arbiter: stimulus queues expected products,
// a negedge monitor pops and checks them whenever result_valid is non-zero.
module tb_discrete_mult_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic              clk = 1'b0;
  logic              I_RSTn;
  logic              audio_clk_en;
  logic [N-1:0]      req;
  logic [N*W-1:0]    op_a, op_b;
  logic [N-1:0]      gnt;
  logic [W-1:0]      result;
  logic [N-1:0]      result_valid;
  logic              busy, overrun;

  typedef struct {
    logic [N-1:0] own;
    logic [W-1:0] res;
  } exp_t;

  exp_t expq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  discrete_mult_arbiter #(.NUM_REQ(N), .SIGNAL_WIDTH(W), .SIGNAL_FRACTION_WIDTH(14)) dut (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .req          (req),
    .op_a         (op_a),
    .op_b         (op_b),
    .gnt          (gnt),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic push(input logic [N-1:0] own, input logic [W-1:0] res);
    exp_t e;
    e.own = own;
    e.res = res;
    expq.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    I_RSTn = 1'b0;
    req    = '0;
    audio_clk_en = 1'b0;
    next_cycle();
    next_cycle();
    I_RSTn = 1'b1;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (I_RSTn && result_valid != '0) begin
        if (expq.size() == 0) begin
          chk("unexpected_result_valid", 32'(result_valid), 32'h0);
        end else begin
          e = expq.pop_front();
          chk("result_valid_owner", 32'(result_valid), 32'(e.own));
          chk("result_value", 32'(result), 32'(e.res));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  logic [W-1:0] va [5];
  logic [W-1:0] vb [5];
  logic [W-1:0] vr [5];

  initial begin
    op_a = '0;
    op_b = '0;
    do_reset();
    I_RSTn = 1'b0;
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_result_valid", 32'(result_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    next_cycle();
    I_RSTn = 1'b1;

    // Single request: 1.0 * 0.5 = 0.5
    set_op(0, 16'h4000, 16'h2000);
    req = 4'b0001;
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h1);
    push(4'b0001, 16'h2000);
    next_cycle();
    req = 4'b0000;
    @(negedge clk);
    chk("busy_stage1", 32'(busy), 32'h1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("result_hold", 32'(result), 32'h2000);
    chk("idle_busy", 32'(busy), 32'h0);

    // Back-to-back arithmetic corners, one per cycle
    va[0] = 16'h7FFF; vb[0] = 16'h7FFF; vr[0] = 16'h7FFF;
    va[1] = 16'h8000; vb[1] = 16'h8000; vr[1] = 16'h7FFF;
    va[2] = 16'hC000; vb[2] = 16'h2000; vr[2] = 16'hE000;
    va[3] = 16'h0001; vb[3] = 16'h0001; vr[3] = 16'h0000;
    va[4] = 16'hFFFF; vb[4] = 16'h0001; vr[4] = 16'hFFFF;
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      set_op(k % N, va[k], vb[k]);
      req = 4'(1 << (k % N));
      @(negedge clk);
      chk("arith_gnt", 32'(gnt), 32'(1 << (k % N)));
      push(4'(1 << (k % N)), vr[k]);
      next_cycle();
    end
    req = '0;
    repeat (4) next_cycle();

    // All requesters held from reset: strict rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 16'h4000, 16'((i + 1) * 16'h0100));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_all_gnt", 32'(gnt), 32'(1 << (k % N)));
      push(4'(1 << (k % N)), 16'(((k % N) + 1) * 16'h0100));
      next_cycle();
    end
    req = '0;
    repeat (4) next_cycle();

    // Grant to 2, then 0101 -> 0 then 2
    set_op(0, 16'h4000, 16'h0567);
    set_op(2, 16'h4000, 16'h1234);
    req = 4'b0100;
    @(negedge clk);
    chk("rr_gnt2", 32'(gnt), 32'h4);
    push(4'b0100, 16'h1234);
    next_cycle();
    req = 4'b0101;
    @(negedge clk);
    chk("rr_wrap_gnt0", 32'(gnt), 32'h1);
    push(4'b0001, 16'h0567);
    next_cycle();
    @(negedge clk);
    chk("rr_then_gnt2", 32'(gnt), 32'h4);
    push(4'b0100, 16'h1234);
    next_cycle();
    req = '0;
    repeat (4) next_cycle();

    // Strobe with idle pipeline and no requests: no overrun
    audio_clk_en = 1'b1;
    next_cycle();
    audio_clk_en = 1'b0;
    @(negedge clk);
    chk("overrun_idle", 32'(overrun), 32'h0);
    next_cycle();

    // Strobe while a request is left waiting: pointer is 3, so 0 wins first
    set_op(0, 16'h4000, 16'h0111);
    set_op(1, 16'h4000, 16'h0222);
    req = 4'b0011;
    audio_clk_en = 1'b1;
    @(negedge clk);
    chk("ovr_gnt0", 32'(gnt), 32'h1);
    push(4'b0001, 16'h0111);
    next_cycle();
    audio_clk_en = 1'b0;
    @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'h1);
    chk("ovr_gnt1", 32'(gnt), 32'h2);
    push(4'b0010, 16'h0222);
    next_cycle();
    req = '0;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("ovr_sticky", 32'(overrun), 32'h1);

    // Reset with a product in flight: it must never emerge
    next_cycle();
    set_op(0, 16'h4000, 16'h0777);
    req = 4'b0001;
    @(negedge clk);
    chk("inflight_gnt", 32'(gnt), 32'h1);
    next_cycle();
    I_RSTn = 1'b0;
    req = '0;
    @(negedge clk);
    chk("midrst_result", 32'(result), 32'h0);
    chk("midrst_valid", 32'(result_valid), 32'h0);
    chk("midrst_overrun", 32'(overrun), 32'h0);
    next_cycle();
    I_RSTn = 1'b1;
    set_op(1, 16'h4000, 16'h0999);
    set_op(3, 16'h4000, 16'h0AAA);
    req = 4'b1010;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'h2);
    push(4'b0010, 16'h0999);
    next_cycle();
    req = '0;
    repeat (5) next_cycle();

    chk("scoreboard_drained", 32'(expq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
